// File: rtl/uart_rx_param_driver.sv
// -----------------------------------------------------------------------------
// uart_rx_param_driver
//
// Single-clock UART receiver with configurable data width, parity mode,
// stop-bit count and oversampling ratio. Every bit is settled by a 3-sample
// majority vote around the bit centre. Each completed character is presented
// as a one-cycle pulse on out_ready, with parity, framing and break flags.
//
// Parameters
//   CYCLES_PER_BIT  clk cycles per bit (>= 4)
//   DATA_BITS       data bits per character, LSB first (5..9)
//   PARITY          0 = none, 1 = odd, 2 = even
//   STOP_BITS       stop bits checked (1 or 2)
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   rxd         asynchronous serial input, idles high
//   out         received character, meaningful while out_ready = 1
//   out_ready   one-cycle pulse when a character completes
//   parity_err  parity mismatch (always 0 when PARITY = 0)
//   frame_err   a checked stop bit was decided as 0
//   break_det   every data, parity and stop bit was 0 (implies frame_err)
// -----------------------------------------------------------------------------
module uart_rx_param_driver #(
  parameter int CYCLES_PER_BIT = 10,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] out,
  output logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det
);

  localparam int CNT_W  = (CYCLES_PER_BIT > 2) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIDX_W = $clog2(DATA_BITS);
  localparam int H      = CYCLES_PER_BIT / 2;

  // Bit-timing landmarks: three samples around the centre, decided at H+1.
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(H);
  localparam logic [CNT_W-1:0]  CNT_DEC   = CNT_W'(H + 1);
  localparam logic [BIDX_W-1:0] BIT_LAST  = BIDX_W'(DATA_BITS - 1);
  localparam logic              STOP_LAST = (STOP_BITS == 2);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q;
  logic [1:0]          sync_q;       // sync_q[1] is the synchronised line rxd_s
  logic [1:0]          sync_ok_q;    // synchroniser holds real pin samples
  logic                armed_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [BIDX_W-1:0]   bit_idx_q;
  logic                stop_idx_q;
  logic [1:0]          smp_q;        // samples taken at H-1 and H
  logic [DATA_BITS-1:0] shift_q;
  logic                perr_acc_q;
  logic                ferr_acc_q;
  logic                ones_q;       // any decided bit of this frame was 1
  logic [DATA_BITS-1:0] out_q;
  logic                out_ready_q;
  logic                parity_err_q;
  logic                frame_err_q;
  logic                break_det_q;

  logic             rxd_s;
  logic             maj_d;
  logic             at_dec;
  logic             at_wrap;
  logic [CNT_W-1:0] cnt_d;
  logic             par_bad_d;

  assign rxd_s   = sync_q[1];
  // The third sample is the live synchronised value at the decision count.
  assign maj_d   = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxd_s) | (smp_q[1] & rxd_s);
  assign at_dec  = (cnt_q == CNT_DEC);
  assign at_wrap = (cnt_q == CNT_LAST);
  assign cnt_d   = at_wrap ? '0 : cnt_q + 1'b1;
  // Odd mode wants XOR(data, parity) = 1, even mode wants 0.
  assign par_bad_d = (^shift_q) ^ maj_d ^ ODD_PAR;

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= 2'b11;
      sync_ok_q    <= 2'b00;
      state_q      <= S_IDLE;
      armed_q      <= 1'b0;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      smp_q        <= 2'b00;
      shift_q      <= '0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      ones_q       <= 1'b0;
      out_q        <= '0;
      out_ready_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd};
      // The synchroniser reset value of 1 is not a real line sample; hold off
      // arming until both stages have been refilled from the pin, so a reset
      // in the middle of a low frame cannot arm on the stale ones.
      sync_ok_q   <= {sync_ok_q[0], 1'b1};
      out_ready_q <= 1'b0;

      if (cnt_q == CNT_PRE) smp_q[0] <= rxd_s;
      if (cnt_q == CNT_MID) smp_q[1] <= rxd_s;

      case (state_q)
        S_IDLE: begin
          if (rxd_s && sync_ok_q[1]) armed_q <= 1'b1;
          // The first low cycle seen here is count 0 of the start bit.
          if (armed_q && !rxd_s) begin
            state_q    <= S_START;
            cnt_q      <= CNT_W'(1);
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            ones_q     <= 1'b0;
          end
        end

        S_START: begin
          cnt_q <= cnt_d;
          if (at_dec && maj_d) begin
            // Start bit voted high: treat as a glitch.
            state_q <= S_IDLE;
            armed_q <= 1'b0;
            cnt_q   <= '0;
          end else if (at_wrap) begin
            state_q <= S_DATA;
          end
        end

        S_DATA: begin
          cnt_q <= cnt_d;
          if (at_dec) begin
            shift_q <= {maj_d, shift_q[DATA_BITS-1:1]};
            ones_q  <= ones_q | maj_d;
          end
          if (at_wrap) begin
            bit_idx_q <= bit_idx_q + 1'b1;
            if (bit_idx_q == BIT_LAST) state_q <= HAS_PAR ? S_PARITY : S_STOP;
          end
        end

        S_PARITY: begin
          cnt_q <= cnt_d;
          if (at_dec) begin
            perr_acc_q <= par_bad_d;
            ones_q     <= ones_q | maj_d;
          end
          if (at_wrap) state_q <= S_STOP;
        end

        S_STOP: begin
          cnt_q <= cnt_d;
          if (at_dec) begin
            if (stop_idx_q == STOP_LAST) begin
              // Finish at the centre of the last stop bit rather than its end,
              // leaving half a bit of margin for a faster transmitter clock.
              state_q      <= S_IDLE;
              armed_q      <= 1'b0;
              cnt_q        <= '0;
              out_q        <= shift_q;
              out_ready_q  <= 1'b1;
              parity_err_q <= perr_acc_q;
              frame_err_q  <= ferr_acc_q | ~maj_d;
              break_det_q  <= ~(ones_q | maj_d);
            end else begin
              ferr_acc_q <= ferr_acc_q | ~maj_d;
              ones_q     <= ones_q | maj_d;
            end
          end
          if (at_wrap) stop_idx_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign out        = out_q;
  assign out_ready  = out_ready_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_param_driver.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param_driver
//
// Directed bench for uart_rx_param_driver. Three instances cover the 8N1
// default, 8E1 and 7N2 configurations, all at 10 cycles per bit. Each line is
// driven one cycle at a time from a bit vector (bit 0 = start bit). Small
// negedge monitors count out_ready pulses and capture the values presented
// with them; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_uart_rx_param_driver;

  localparam int C = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic rxd_c = 1'b1;

  logic [7:0] out_a, out_b;
  logic [6:0] out_c;
  logic rdy_a, pe_a, fe_a, bd_a;
  logic rdy_b, pe_b, fe_b, bd_b;
  logic rdy_c, pe_c, fe_c, bd_c;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param_driver u_8n1 (
    .clk(clk), .reset(reset), .rxd(rxd_a), .out(out_a), .out_ready(rdy_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a)
  );

  uart_rx_param_driver #(.CYCLES_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset(reset), .rxd(rxd_b), .out(out_b), .out_ready(rdy_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b)
  );

  uart_rx_param_driver #(.CYCLES_PER_BIT(C), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .reset(reset), .rxd(rxd_c), .out(out_c), .out_ready(rdy_c),
    .parity_err(pe_c), .frame_err(fe_c), .break_det(bd_c)
  );

  // Pulse monitors, sampled on the falling edge.
  int np_a = 0, lt_a = 0;
  logic [7:0] lo_a = '0;
  logic lpe_a = 1'b0, lfe_a = 1'b0, lbd_a = 1'b0;
  always @(negedge clk) if (rdy_a) begin
    np_a <= np_a + 1; lt_a <= cyc; lo_a <= out_a;
    lpe_a <= pe_a; lfe_a <= fe_a; lbd_a <= bd_a;
  end

  int np_b = 0;
  logic [7:0] lo_b = '0;
  logic lpe_b = 1'b0, lfe_b = 1'b0, lbd_b = 1'b0;
  always @(negedge clk) if (rdy_b) begin
    np_b <= np_b + 1; lo_b <= out_b;
    lpe_b <= pe_b; lfe_b <= fe_b; lbd_b <= bd_b;
  end

  int np_c = 0;
  int tc[8];
  logic [6:0] oc[8];
  logic err_c = 1'b0;
  always @(negedge clk) if (rdy_c) begin
    np_c <= np_c + 1;
    if (np_c < 8) begin
      tc[np_c] <= cyc;
      oc[np_c] <= out_c;
    end
    err_c <= err_c | pe_c | fe_c | bd_c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    case (which)
      0:       rxd_a = v;
      1:       rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // Drives nbits bit-times from 'bits' (bit 0 first). glitch_k inverts the
  // line for that single cycle; reset_k pulses reset for that single cycle.
  task automatic send_frame(input int which, input logic [15:0] bits, input int nbits,
                            input int glitch_k, input int reset_k);
    logic v;
    for (int k = 0; k < nbits * C; k++) begin
      v = bits[k / C];
      if (k == glitch_k) v = ~v;
      set_line(which, v);
      reset = (k == reset_k);
      tick(1);
    end
    set_line(which, 1'b1);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] fr8n1(input logic [7:0] d, input logic stop);
    return {6'b111111, stop, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr8e1(input logic [7:0] d, input logic p);
    return {5'b11111, 1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] fr7n2(input logic [6:0] d);
    return {6'b111111, 2'b11, d, 1'b0};
  endfunction

  initial begin
    int t0;

    // Reset state.
    tick(3);
    check("rst_out_ready", {31'b0, rdy_a}, 32'd0);
    check("rst_out", {24'b0, out_a}, 32'h00);
    check("rst_flags", {29'b0, pe_a, fe_a, bd_a}, 32'd0);
    check("rst_out_b", {24'b0, out_b}, 32'h00);
    check("rst_out_c", {25'b0, out_c}, 32'h00);
    reset = 1'b0;
    tick(6);

    // 8N1 0xA5: pulse 99 cycles after the pin edge.
    t0 = cyc;
    send_frame(0, fr8n1(8'hA5, 1'b1), 10, -1, -1);
    tick(20);
    check("a5_pulses", np_a, 32'd1);
    check("a5_latency", lt_a - t0, 32'd99);
    check("a5_out", {24'b0, lo_a}, 32'hA5);
    check("a5_flags", {29'b0, lpe_a, lfe_a, lbd_a}, 32'd0);

    // 8E1 0x07: parity bit 1 is correct, 0 is wrong.
    send_frame(1, fr8e1(8'h07, 1'b1), 11, -1, -1);
    tick(20);
    check("par_ok_pulses", np_b, 32'd1);
    check("par_ok_out", {24'b0, lo_b}, 32'h07);
    check("par_ok_perr", {31'b0, lpe_b}, 32'd0);
    check("par_ok_ferr", {31'b0, lfe_b}, 32'd0);
    send_frame(1, fr8e1(8'h07, 1'b0), 11, -1, -1);
    tick(20);
    check("par_bad_pulses", np_b, 32'd2);
    check("par_bad_out", {24'b0, lo_b}, 32'h07);
    check("par_bad_perr", {31'b0, lpe_b}, 32'd1);
    check("par_bad_ferr", {31'b0, lfe_b}, 32'd0);

    // Stop bit forced low on 0x3C: framing error but no break.
    send_frame(0, fr8n1(8'h3C, 1'b0), 10, -1, -1);
    tick(30);
    check("frm_pulses", np_a, 32'd2);
    check("frm_out", {24'b0, lo_a}, 32'h3C);
    check("frm_ferr", {31'b0, lfe_a}, 32'd1);
    check("frm_break", {31'b0, lbd_a}, 32'd0);

    // Line held low for 40 bit-times: exactly one break character.
    set_line(0, 1'b0);
    tick(40 * C);
    check("brk_pulses", np_a, 32'd3);
    check("brk_out", {24'b0, lo_a}, 32'h00);
    check("brk_ferr", {31'b0, lfe_a}, 32'd1);
    check("brk_break", {31'b0, lbd_a}, 32'd1);
    set_line(0, 1'b1);
    tick(30);
    check("brk_no_repeat", np_a, 32'd3);

    // 3-cycle low pulse on an idle line is rejected as a false start.
    set_line(0, 1'b0);
    tick(3);
    set_line(0, 1'b1);
    tick(40);
    check("glitch_start", np_a, 32'd3);

    // 0x00 with a one-cycle high glitch at the centre of data bit 3.
    send_frame(0, fr8n1(8'h00, 1'b1), 10, 4 * C + C / 2, -1);
    tick(20);
    check("vote_pulses", np_a, 32'd4);
    check("vote_out", {24'b0, lo_a}, 32'h00);
    check("vote_flags", {29'b0, lpe_a, lfe_a, lbd_a}, 32'd0);

    // 7N2: four 0x55 characters back to back.
    for (int i = 0; i < 4; i++) send_frame(2, fr7n2(7'h55), 10, -1, -1);
    tick(20);
    check("b2b_pulses", np_c, 32'd4);
    check("b2b_gap1", tc[1] - tc[0], 32'd100);
    check("b2b_gap2", tc[2] - tc[1], 32'd100);
    check("b2b_gap3", tc[3] - tc[2], 32'd100);
    check("b2b_out0", {25'b0, oc[0]}, 32'h55);
    check("b2b_out1", {25'b0, oc[1]}, 32'h55);
    check("b2b_out2", {25'b0, oc[2]}, 32'h55);
    check("b2b_out3", {25'b0, oc[3]}, 32'h55);
    check("b2b_errors", {31'b0, err_c}, 32'd0);

    // Reset in the middle of data bit 4; the rest of the frame stays low.
    send_frame(0, fr8n1(8'h00, 1'b1), 10, -1, 5 * C + C / 2);
    tick(30);
    check("abort_no_pulse", np_a, 32'd4);
    send_frame(0, fr8n1(8'h81, 1'b1), 10, -1, -1);
    tick(20);
    check("after_rst_pulses", np_a, 32'd5);
    check("after_rst_out", {24'b0, lo_a}, 32'h81);
    check("after_rst_flags", {29'b0, lpe_a, lfe_a, lbd_a}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_param_driver.md
Name: uart_rx_param_driver

Overview:
Generalised single-clock UART receiver, successor to the fixed 8N1 fast receiver. It has configurable data width, parity mode, stop-bit count and oversampling ratio. Each bit is decided by a 3-sample majority vote, and the block reports parity, framing and break errors per character. It sits between the board rxd pin and byte-stream consumers, with the same pulse-style out/out_ready interface.

Parameters:
CYCLES_PER_BIT, 10, clk cycles per bit; legal range is 4 or more.
DATA_BITS, 8, data bits per character, received LSB first; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits checked; legal values 1 or 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rxd  in  1  asynchronous serial input; idles high.
out  out  DATA_BITS  received character; valid only while out_ready=1.
out_ready  out  1  one-cycle pulse when a character completes.
parity_err  out  1  parity mismatch; qualified by out_ready; always 0 when PARITY=0.
frame_err  out  1  some checked stop bit was sampled 0; qualified by out_ready.
break_det  out  1  all data bits, the parity bit (if present) and the stop bits were all 0; qualified by out_ready; implies frame_err.

Behaviour:
- Single clock domain: clk. reset is synchronous and active-high; no other reset exists.
- Reset values: out_ready, parity_err, frame_err, break_det = 0; out = 0; state = IDLE; armed = 0.
- rxd passes through a 2-flop synchroniser (rxd_s) initialised to 1. Latency from pin to rxd_s is 2 cycles.
- Bit timing:
  - Counter cnt has width clog2(CYCLES_PER_BIT); it runs from 0 to CYCLES_PER_BIT-1 and then wraps.
  - H = CYCLES_PER_BIT/2.
  - rxd_s is sampled at cnt = H-1, H and H+1. The bit value is the majority of the three samples, decided at cnt = H+1.
- armed:
  - Set when rxd_s=1 in IDLE.
  - Cleared on reset and on every return to IDLE.
  - A start edge is accepted only while armed=1. This prevents retriggering on a held-low line after a break or after reset mid-frame.
- IDLE:
  - If armed and rxd_s=0, go to START with cnt=0 on the next cycle.
  - That first low cycle counts as cnt 0.
- START: at the decision point, majority=1 means a glitch: return to IDLE with no output. Otherwise continue to DATA at the cnt wrap.
- DATA:
  - DATA_BITS bits, shifted in LSB first.
  - After the last data bit, go to PARITY if PARITY != 0, else to STOP.
- PARITY:
  - Odd mode requires XOR(data, parity bit) = 1.
  - Even mode requires XOR(data, parity bit) = 0.
  - A mismatch latches the parity error.
- STOP:
  - STOP_BITS bits; any stop bit decided as 0 latches the frame error.
  - At the decision point of the final stop bit, go to IDLE immediately, without waiting for the end of the bit, to gain clock-tolerance margin.
  - On the next cycle, drive out_ready=1 together with out and the flags for exactly one cycle.
- Flags and out hold their values between pulses but are meaningful only with out_ready. The internal error accumulators clear at each START entry.
- Frame-end latency (8N1, CYCLES_PER_BIT=10): pin falling edge at cycle t0 gives out_ready at t0+99. Generally, out_ready comes 2 + (frame_bits-1)*CYCLES_PER_BIT + H+1 + 1 cycles after the pin edge.
- There is no backpressure. A new start edge is accepted in the cycle after the return to IDLE, once rxd_s is high and armed is set.
- Reset mid-frame: the partial character is discarded with no out_ready pulse, and the block needs rxd_s high again before the next start.
- A single-cycle glitch inside any bit is out-voted by the majority decision and does not change the decided value.

Test Plan:
- 8N1, CYCLES_PER_BIT=10, send 0xA5 with a pin edge at t0 -> out_ready pulses exactly once at t0+99, out=0xA5, all flags 0.
- PARITY=2, send 0x07 with parity bit 1 -> out=0x07, parity_err=0. Resend with parity bit 0 -> parity_err=1 and out=0x07.
- 8N1, send 0x3C with the stop bit forced to 0 -> frame_err=1, break_det=0. Then hold rxd low 40 bit-times -> exactly one pulse with out=0x00, frame_err=1, break_det=1, and no further pulses until rxd returns high.
- Drive a 3-cycle low pulse on an idle line -> no out_ready. Drive a 1-cycle high glitch at cnt=H of data bit 3 of 0x00 -> out=0x00.
- DATA_BITS=7, STOP_BITS=2, send 0x55 back-to-back ×4 -> four pulses spaced 10*CYCLES_PER_BIT cycles apart, all out=0x55, no errors.
- Assert reset for 1 cycle at mid data bit 4 of a frame, then send 0x81 after the line idles -> no pulse for the aborted frame, then out=0x81 with clean flags.
